// File: rtl/jk_pkg.sv
// Shared types and limits for the JK multimode register bank.
package jk_pkg;

  localparam int unsigned JK_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    JK_MODE_JK    = 2'd0,
    JK_MODE_LOAD  = 2'd1,
    JK_MODE_COUNT = 2'd2,
    JK_MODE_SHIFT = 2'd3
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable and synchronous active-high reset to rst_val.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (ce) begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_multimode_reg.sv
// WIDTH-bit register bank of JK cells: per-bit JK, parallel load, up/down count, left shift.
// Define JK_MULTIMODE_SAT_EN to make COUNT mode saturate instead of wrapping.
module jk_multimode_reg
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             ser_out,
  output logic             tc
);

  if (WIDTH < 2 || WIDTH > JK_MAX_WIDTH) begin : g_width_check
    $error("jk_multimode_reg: WIDTH out of range");
  end

  jk_mode_t         w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_shift;
  logic             w_at_limit;

  assign w_mode     = jk_mode_t'(mode);
  assign w_at_limit = up ? (&w_q) : ~(|w_q);
  assign w_shift    = {w_q[WIDTH-2:0], ser_in};

  // Counting as JK toggles: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic v_chain;
    w_toggle = '0;
    v_chain  = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_toggle[i] = v_chain;
      v_chain     = v_chain & (up ? w_q[i] : ~w_q[i]);
    end
`ifdef JK_MULTIMODE_SAT_EN
    if (w_at_limit) w_toggle = '0;
`endif
  end

  always_comb begin
    w_j = '0;
    w_k = '0;
    unique case (w_mode)
      JK_MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      JK_MODE_LOAD: begin
        w_j = d;
        w_k = ~d;
      end
      JK_MODE_COUNT: begin
        w_j = w_toggle;
        w_k = w_toggle;
      end
      JK_MODE_SHIFT: begin
        w_j = w_shift;
        w_k = ~w_shift;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[gi]),
      .ce      (en),
      .j       (w_j[gi]),
      .k       (w_k[gi]),
      .q       (w_q[gi])
    );
  end

  assign q       = w_q;
  assign q_not   = ~w_q;
  assign ser_out = w_q[WIDTH-1];
  assign tc      = (w_mode == JK_MODE_COUNT) && en && w_at_limit;

endmodule

// File: tb/tb_jk_multimode_reg.sv
// Scoreboard bench for jk_multimode_reg (WIDTH=8, RESET_VAL=0); honours JK_MULTIMODE_SAT_EN.
module tb_jk_multimode_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j, k, d;
  logic       up;
  logic       ser_in;
  logic [7:0] q, q_not;
  logic       ser_out, tc;

  typedef struct {
    string      name;
    logic [7:0] exp_q;
    logic       exp_tc;
  } exp_t;

  exp_t exp_q_fifo[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  jk_multimode_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .d       (d),
    .up      (up),
    .ser_in  (ser_in),
    .q       (q),
    .q_not   (q_not),
    .ser_out (ser_out),
    .tc      (tc)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_fifo.size() > 0) begin
        exp_t e;
        logic [7:0] e_qn;
        e    = exp_q_fifo.pop_front();
        e_qn = ~e.exp_q;
        check({e.name, ".q"},       q,             e.exp_q);
        check({e.name, ".q_not"},   q_not,         e_qn);
        check({e.name, ".ser_out"}, {7'd0, ser_out}, {7'd0, e.exp_q[7]});
        check({e.name, ".tc"},      {7'd0, tc},      {7'd0, e.exp_tc});
      end
    end
  end

  // Drive one cycle of inputs on the falling edge and record the expected post-edge state.
  task automatic step(input string name, input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd,
                      input logic u, input logic si,
                      input logic [7:0] eq, input logic etc);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; j = jj; k = kk; d = dd; up = u; ser_in = si;
    x.name = name; x.exp_q = eq; x.exp_tc = etc;
    exp_q_fifo.push_back(x);
  endtask

  logic [7:0] sat_up_q, sat_dn_q;
  logic       sat_up_tc, sat_dn_tc;

  initial begin
`ifdef JK_MULTIMODE_SAT_EN
    sat_up_q = 8'hFF; sat_up_tc = 1'b1;
    sat_dn_q = 8'h00; sat_dn_tc = 1'b1;
`else
    sat_up_q = 8'h00; sat_up_tc = 1'b0;
    sat_dn_q = 8'hFF; sat_dn_tc = 1'b0;
`endif
    rst = 1'b1; en = 1'b1; mode = 2'd2; j = '0; k = '0; d = '0; up = 1'b1; ser_in = 1'b0;

    //    name          rst en mode j      k      d      up si  exp_q  tc
    step("rst0",        1, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    step("rst1",        1, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    step("cnt_resume0", 0, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h01, 0);
    step("cnt_resume1", 0, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h02, 0);
    step("rst2",        1, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    step("jk_set_rst",  0, 1, 0, 8'hF0, 8'h0F, 8'hAA, 1, 1, 8'hF0, 0);
    step("jk_toggle",   0, 1, 0, 8'hFF, 8'hFF, 8'hAA, 1, 1, 8'h0F, 0);
    step("jk_hold",     0, 1, 0, 8'h00, 8'h00, 8'hAA, 1, 1, 8'h0F, 0);
    step("jk_en0",      0, 0, 0, 8'hFF, 8'hFF, 8'hAA, 1, 1, 8'h0F, 0);
    step("load_FE",     0, 1, 1, 8'hFF, 8'h00, 8'hFE, 1, 0, 8'hFE, 0);
    step("up_FF",       0, 1, 2, 8'h00, 8'hFF, 8'h00, 1, 0, 8'hFF, 1);
    step("up_wrap",     0, 1, 2, 8'h00, 8'hFF, 8'h00, 1, 0, sat_up_q, sat_up_tc);
    step("load_01",     0, 1, 1, 8'h00, 8'h00, 8'h01, 0, 0, 8'h01, 0);
    step("dn_00",       0, 1, 2, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    step("dn_wrap",     0, 1, 2, 8'h00, 8'h00, 8'h00, 0, 0, sat_dn_q, sat_dn_tc);
    step("load_00",     0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    step("dn_en0_tc",   0, 0, 2, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    step("load_81",     0, 1, 1, 8'h00, 8'h00, 8'h81, 0, 0, 8'h81, 0);
    step("shift0",      0, 1, 3, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'h02, 0);
    step("shift1",      0, 1, 3, 8'hFF, 8'hFF, 8'h00, 1, 1, 8'h05, 0);
    step("shift2",      0, 1, 3, 8'hFF, 8'hFF, 8'h00, 1, 1, 8'h0B, 0);
    step("load_36",     0, 1, 1, 8'h00, 8'h00, 8'h36, 1, 0, 8'h36, 0);
    step("up_37",       0, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h37, 0);
    step("rst_midcnt",  1, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    step("sw_load0",    0, 1, 1, 8'h00, 8'h00, 8'h55, 1, 0, 8'h55, 0);
    step("sw_cnt0",     0, 1, 2, 8'h00, 8'h00, 8'h55, 1, 0, 8'h56, 0);
    step("sw_load1",    0, 1, 1, 8'h00, 8'h00, 8'h55, 1, 0, 8'h55, 0);
    step("sw_cnt1",     0, 1, 2, 8'h00, 8'h00, 8'h55, 1, 0, 8'h56, 0);

    for (int i = 0; i < 20 && exp_q_fifo.size() > 0; i++) @(negedge clk);
    if (exp_q_fifo.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q_fifo.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
